// File: rtl/koa_seq_mult.sv
// Sequential Karatsuba significand multiplier: one shared (L+1)x(L+1) multiplier
// produces the three sub-products over three cycles, then a fourth cycle combines them.
module koa_seq_mult #(
    parameter int unsigned SW   = 24,
    parameter int unsigned LOWL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            approx_i,
    input  logic [SW-1:0]   Data_A_i,
    input  logic [SW-1:0]   Data_B_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [2*SW-1:0] sgf_result_o
);

    localparam int unsigned H  = SW / 2;
    localparam int unsigned L  = SW - H;
    localparam int unsigned M  = L + 1;
    localparam int unsigned PW = 2 * M;
    localparam int unsigned RW = 2 * SW;

    // Bits of the pre-adders that are OR-ed instead of added in approximate mode.
    localparam logic [M-1:0] LOW_MASK = M'((64'd1 << LOWL) - 64'd1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MLOW  = 3'd1,
        MHIGH = 3'd2,
        MMID  = 3'd3,
        COMB  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic          accept_c;
    logic          load_low_c;
    logic          load_high_c;
    logic          load_mid_c;
    logic          load_res_c;

    logic [SW-1:0]  a_q;
    logic [SW-1:0]  b_q;
    logic           approx_q;
    logic [2*L-1:0] p_low;
    logic [2*H-1:0] p_high;
    logic [PW-1:0]  p_mid;

    logic [M-1:0]   ah;
    logic [M-1:0]   al;
    logic [M-1:0]   bh;
    logic [M-1:0]   bl;
    logic [M-1:0]   sa;
    logic [M-1:0]   sb;
    logic [M-1:0]   mul_a;
    logic [M-1:0]   mul_b;
    logic [PW-1:0]  prod;
    logic [RW-1:0]  mid_term;
    logic [RW-1:0]  combined;

    // Exact add, or carry-free OR on the low LOWL bits plus exact add above them.
    function automatic logic [M-1:0] pre_add(input logic [M-1:0] hi,
                                             input logic [M-1:0] lo,
                                             input logic         approx);
        logic [M-1:0] exact_sum;
        logic [M-1:0] upper_sum;
        exact_sum = hi + lo;
        upper_sum = (hi & ~LOW_MASK) + (lo & ~LOW_MASK);
        return approx ? (upper_sum | ((hi | lo) & LOW_MASK)) : exact_sum;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = MLOW;
            MLOW:    state_next = MHIGH;
            MHIGH:   state_next = MMID;
            MMID:    state_next = COMB;
            COMB:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        accept_c    = 1'b0;
        load_low_c  = 1'b0;
        load_high_c = 1'b0;
        load_mid_c  = 1'b0;
        load_res_c  = 1'b0;
        case (state)
            IDLE:    accept_c    = start_i;
            MLOW:    load_low_c  = 1'b1;
            MHIGH:   load_high_c = 1'b1;
            MMID:    load_mid_c  = 1'b1;
            COMB:    load_res_c  = 1'b1;
            default: ;
        endcase
    end

    // Operand halves, zero-extended to the shared multiplier width
    always_comb begin
        ah = M'(a_q[SW-1:L]);
        al = M'(a_q[L-1:0]);
        bh = M'(b_q[SW-1:L]);
        bl = M'(b_q[L-1:0]);
        sa = pre_add(ah, al, approx_q);
        sb = pre_add(bh, bl, approx_q);
    end

    // Shared multiplier operand select
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MLOW: begin
                mul_a = al;
                mul_b = bl;
            end
            MHIGH: begin
                mul_a = ah;
                mul_b = bh;
            end
            MMID: begin
                mul_a = sa;
                mul_b = sb;
            end
            default: ;
        endcase
    end

    assign prod = PW'(mul_a) * PW'(mul_b);

    // Karatsuba recombination; the middle term wraps modulo 2^(2SW) when negative
    always_comb begin
        mid_term = RW'(p_mid) - RW'(p_high) - RW'(p_low);
        combined = (RW'(p_high) << (2 * L)) + (mid_term << L) + RW'(p_low);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q          <= '0;
            b_q          <= '0;
            approx_q     <= 1'b0;
            p_low        <= '0;
            p_high       <= '0;
            p_mid        <= '0;
            sgf_result_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q      <= Data_A_i;
                b_q      <= Data_B_i;
                approx_q <= approx_i;
            end
            if (load_low_c) begin
                p_low <= prod[2*L-1:0];
            end
            if (load_high_c) begin
                p_high <= prod[2*H-1:0];
            end
            if (load_mid_c) begin
                p_mid <= prod;
            end
            if (load_res_c) begin
                sgf_result_o <= combined;
            end
            busy_o <= (state_next != IDLE);
            done_o <= load_res_c;
        end
    end

endmodule
